bitfield_reader: RTL and testbench

BITFIELD_READER -- requirements
Module: bitfield_reader

---
 rtl/bitfield_pkg.sv | 8 +
 rtl/bitfield_align.sv | 16 +
 rtl/bitfield_reader.sv | 78 +++++++
 tb/tb_bitfield_reader.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bitfield_pkg.sv
// bitfield_pkg: shared state encoding, word width and request legality check for bitfield_reader
package bitfield_pkg;
   localparam int WORD_W = 32;
   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WAIT, RESP} state_t;
   function automatic logic width_ok(input int unsigned off, input int unsigned width, input int unsigned words);
      return width != 0 && width <= WORD_W && off + width <= words * WORD_W;
   endfunction
endpackage

// File: rtl/bitfield_align.sv
// bitfield_align: shifts the {hi,lo} word pair right and masks the result to the field width
module bitfield_align
   import bitfield_pkg::*;
(
   input  logic [WORD_W-1:0] hi,
   input  logic [WORD_W-1:0] lo,
   input  logic [4:0]        shift,
   input  logic [5:0]        width,
   output logic [WORD_W-1:0] field
);
   logic [WORD_W-1:0] w_mask;
   always_comb begin
      w_mask = width >= 6'd32 ? '1 : (WORD_W'(1) << width) - WORD_W'(1);
      field  = WORD_W'({hi, lo} >> shift) & w_mask;
   end
endmodule

// File: rtl/bitfield_reader.sv
// bitfield_reader: reads an arbitrary 1..32-bit field from a word-packed store via one or two word reads
module bitfield_reader
   import bitfield_pkg::*;
#(
   parameter int MEM_WORDS = 3,
   parameter int OFF_W     = 7
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [OFF_W-1:0]             req_offset,
   input  logic [5:0]                   req_width,
   output logic                         mem_en,
   output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
   input  logic [WORD_W-1:0]            mem_rdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [WORD_W-1:0]            rsp_data,
   output logic                         rsp_err
);
   localparam int AW = $clog2(MEM_WORDS);
   state_t            r_state, w_next;
   logic [OFF_W-1:0]  r_off;
   logic [5:0]        r_width;
   logic [WORD_W-1:0] r_lo, r_data, w_field;
   logic              r_err, w_hs, w_legal, w_two;
   logic [AW-1:0]     w_base;
   assign w_hs      = req_valid && req_ready;
   assign w_legal   = width_ok(32'(req_offset), 32'(req_width), MEM_WORDS);
   assign w_two     = {2'b0, r_off[4:0]} + {1'b0, r_width} > 7'd32;
   assign w_base    = AW'(r_off >> 5);
   assign req_ready = r_state == IDLE;
   assign mem_en    = r_state == RD_LO || r_state == RD_HI;
   assign mem_addr  = r_state == RD_HI ? w_base + AW'(1) : r_state == RD_LO ? w_base : '0;
   assign rsp_valid = r_state == RESP;
   assign rsp_data  = r_data;
   assign rsp_err   = r_err;
   // a single-word field sits in the low half; a straddling field pairs the earlier word with the one arriving now
   bitfield_align u_align (
      .hi    (w_two ? mem_rdata : '0),
      .lo    (w_two ? r_lo : mem_rdata),
      .shift (r_off[4:0]),
      .width (r_width),
      .field (w_field)
   );
   always_ff @(posedge clk)
      r_state <= rst ? IDLE : w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_hs ? (w_legal ? RD_LO : RESP) : IDLE;
         RD_LO:   w_next = w_two ? RD_HI : WAIT;
         RD_HI:   w_next = WAIT;
         WAIT:    w_next = RESP;
         RESP:    w_next = rsp_ready ? IDLE : RESP;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_off   <= '0;
         r_width <= '0;
         r_lo    <= '0;
         r_data  <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_hs) begin
            r_off   <= req_offset;
            r_width <= req_width;
            r_err   <= !w_legal;
            r_data  <= '0;
         end
         if (r_state == RD_HI) r_lo <= mem_rdata;
         if (r_state == WAIT) r_data <= w_field;
      end
   end
endmodule

// File: tb/tb_bitfield_reader.sv
// tb_bitfield_reader: scoreboard bench with a bit-level reference model of the packed store
module tb_bitfield_reader;
   logic        clk = 0, rst = 1, req_valid = 0, req_ready, mem_en, rsp_valid, rsp_ready = 1, rsp_err;
   logic [6:0]  req_offset = 0;
   logic [5:0]  req_width = 0;
   logic [1:0]  mem_addr;
   logic [31:0] mem_rdata, rsp_data;
   logic [31:0] mem [3] = '{32'h7801abfe, 32'hf0235689, 32'h000002bc};
   typedef struct {logic [31:0] d; logic e; int lat; int nrd; int a0;} exp_t;
   exp_t q[$];
   int checks = 0, passed = 0, t = 0, hs_t = 0, n_rd = 0, a0 = 0;
   logic prev_v = 0, prev_fire = 0, hold = 1, held_e = 0;
   logic [31:0] held_d = 0;
   bitfield_reader #(.MEM_WORDS(3), .OFF_W(7)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_offset(req_offset), .req_width(req_width), .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );
   always #5 clk = ~clk;
   always @(posedge clk) mem_rdata <= (mem_en && mem_addr < 2'd3) ? mem[mem_addr] : 32'hdeadbeef;
   always @(posedge clk) begin
      #1;
      if (!hold) rsp_ready = $urandom_range(0, 3) != 0;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
   endtask
   function automatic exp_t model(input int off, input int w);
      exp_t x = '{default: 0};
      if (w < 1 || w > 32 || off + w > 96) begin
         x.e = 1;
         x.lat = 1;
      end else begin
         for (int i = 0; i < w; i++) x.d[i] = mem[(off + i) / 32][(off + i) % 32];
         x.a0 = off / 32;
         x.nrd = (off + w - 1) / 32 - off / 32 + 1;
         x.lat = 2 + x.nrd;
      end
      return x;
   endfunction
   always @(negedge clk) begin
      exp_t e;
      t++;
      if (rst) begin
         n_rd = 0;
         prev_v = 0;
         prev_fire = 0;
      end else begin
         if (prev_fire) begin
            chk("ready_after_rsp", {31'b0, req_ready}, 32'd1);
            chk("valid_drop_after_rsp", {31'b0, rsp_valid}, 32'd0);
         end
         if (req_valid && req_ready) begin
            hs_t = t;
            n_rd = 0;
         end
         if (mem_en) begin
            chk("addr_range", {31'b0, mem_addr < 2'd3}, 32'd1);
            if (n_rd == 0) a0 = int'(mem_addr);
            n_rd++;
         end
         if (rsp_valid && !prev_v) begin
            if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               chk("rsp_data", rsp_data, e.d);
               chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.e});
               chk("latency", 32'(t - hs_t), 32'(e.lat));
               chk("mem_reads", 32'(n_rd), 32'(e.nrd));
               if (e.nrd > 0) chk("first_addr", 32'(a0), 32'(e.a0));
            end
            held_d = rsp_data;
            held_e = rsp_err;
         end else if (rsp_valid) begin
            chk("hold_data", rsp_data, held_d);
            chk("hold_err", {31'b0, rsp_err}, {31'b0, held_e});
         end
         if (rsp_valid && !rsp_ready) chk("ready_low_in_resp", {31'b0, req_ready}, 32'd0);
         prev_v = rsp_valid;
         prev_fire = rsp_valid && rsp_ready;
      end
   end
   task automatic send(input int off, input int w);
      int n = 0;
      req_offset = 7'(off);
      req_width = 6'(w);
      req_valid = 1;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 100) chk("req_ready_timeout", 32'd0, 32'd1);
      q.push_back(model(off, w));
      @(posedge clk); #1;
      req_valid = 0;
      req_offset = 7'($urandom);
      req_width = 6'($urandom);
   endtask
   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || rsp_valid) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 500) chk("drain_timeout", 32'(q.size()), 32'd0);
   endtask
   initial begin
      int n, w;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_mem_addr", {30'b0, mem_addr}, 32'd0);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      send(4, 8);
      send(15, 32);
      send(64, 10);
      send(90, 8);
      send(0, 0);
      send(32, 32);
      send(95, 1);
      send(64, 32);
      send(20, 40);
      drain();
      rsp_ready = 0;
      send(4, 8);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 20) chk("stall_rsp_timeout", 32'd0, 32'd1);
      repeat (5) @(posedge clk);
      #1 rsp_ready = 1;
      @(posedge clk); #1;
      drain();
      send(15, 32);
      n = 0;
      while (!(mem_en && mem_addr == 2'd1) && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 10) chk("rd_hi_timeout", 32'd0, 32'd1);
      rst = 1;
      if (q.size() != 0) q.delete(q.size() - 1);
      @(posedge clk); #1;
      rst = 0;
      chk("abort_mem_en", {31'b0, mem_en}, 32'd0);
      chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
      send(4, 8);
      drain();
      hold = 0;
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 3) != 0) begin
            w = $urandom_range(1, 32);
            send($urandom_range(0, 96 - w), w);
         end else send($urandom_range(0, 127), $urandom_range(0, 63));
      end
      drain();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
      $fatal(1);
   end
endmodule
